cork_dispenser_ctrl: RTL and testbench
======================================

Name: cork_dispenser_ctrl

Overview:
Next-generation cork (rolha) dispenser controller for the automatic bottling line. It replaces the single "≥5 corks" input with an internal parametrised stock counter. It serves dispense requests from the capping station with a fixed-length dispense pulse and a completion strobe. It handles operator refill via a held switch, paced at one cork per ADD/gap period, and exports stock level, low-stock and full flags to the line supervisor.

Parameters:
STOCK_W, 6, width of the stock counter; MAX_STOCK < 2**STOCK_W is required.
MAX_STOCK, 20, depot capacity; refill saturates here.
LOW_LEVEL, 5, stock_low asserted while stock < LOW_LEVEL.
INIT_STOCK, 0, stock value loaded on reset; must be ≤ MAX_STOCK.
DISP_CYCLES, 3, cycles disp stays high per cork; must be ≥ 1.
GAP_CYCLES, 1, idle cycles between consecutive add_rolha pulses; must be ≥ 1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
add_sw  in  1  operator refill switch (level)
disp_req  in  1  dispense request from capping station; sampled only in IDLE
disp  out  1  dispense actuator; high for DISP_CYCLES cycles per cork
disp_done  out  1  one-cycle strobe on the last disp cycle
add_rolha  out  1  one-cycle pulse per cork added
stock  out  STOCK_W  current cork count
stock_low  out  1  stock < LOW_LEVEL
stock_full  out  1  stock == MAX_STOCK
busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-high. It forces state=IDLE, stock=INIT_STOCK and the internal cycle counter to 0.
- With reset active, disp, disp_done, add_rolha and busy are 0. stock_low and stock_full are decoded from stock.
- FSM states are IDLE, DISP, ADD and GAP. disp, add_rolha and busy are Moore outputs decoded from state.
- IDLE, priority order:
  - add_sw=1 and stock<MAX_STOCK → ADD (refill has priority over dispense).
  - Else disp_req=1 and stock≠0 → DISP, with the counter cleared.
  - Else stay in IDLE.
  - disp_req with stock=0 is dropped and no dispense occurs.
- DISP:
  - disp=1. The counter increments every cycle.
  - On the cycle where counter==DISP_CYCLES-1: disp_done=1. At the following edge stock decrements by 1 and state → IDLE.
  - add_sw and disp_req are ignored during DISP. A dispense is never aborted except by reset.
- ADD:
  - add_rolha=1 for exactly one cycle.
  - At the next edge stock increments by 1, saturating at MAX_STOCK, and state → GAP with the counter cleared.
  - ADD always completes even if add_sw drops during it.
- GAP:
  - add_sw=0 → IDLE at the next edge.
  - stock==MAX_STOCK → IDLE.
  - Else, when counter==GAP_CYCLES-1 → ADD.
  - Otherwise stay in GAP with the counter incrementing.
- Latency:
  - disp_req sampled high in IDLE at edge k → disp high in cycles k+1..k+DISP_CYCLES.
  - add_sw sampled high in IDLE at edge k → first add_rolha in cycle k+1, then one pulse every GAP_CYCLES+1 cycles.
- stock never wraps. Decrement occurs only from DISP (which requires stock≥1). Increment saturates at MAX_STOCK.
- Reset mid-DISP: disp drops immediately, no disp_done is issued, stock returns to INIT_STOCK.
- Reset mid-ADD: the pending increment is lost.

Optional Feature:
Macro CORK_STARVE_ALARM_EN.
- Defined:
  - Adds output port starve_alarm (1 bit), a sticky register reset to 0.
  - It sets when the FSM is in IDLE with disp_req=1, stock==0 and add_sw=0.
  - It clears in the cycle after any add_rolha pulse.
- Undefined: the port and register are absent, and starved requests are silently dropped.

Test Plan:
1. Reset with INIT_STOCK=0, then hold add_sw for 10 cycles from IDLE → exactly 5 add_rolha pulses spaced 2 cycles apart; stock=5; stock_low falls when stock reaches 5; busy returns to 0.
2. Hold add_sw continuously from stock=0 → stock stops at 20, stock_full=1, FSM in IDLE, no further add_rolha while add_sw remains high.
3. stock=3, one-cycle disp_req → disp high for 3 cycles, disp_done only in the 3rd cycle, stock=2 after the next edge, busy=0 afterwards.
4. stock=0, disp_req held 4 cycles with add_sw=0 → disp stays 0 and stock stays 0. With CORK_STARVE_ALARM_EN, starve_alarm=1 until the first later add_rolha.
5. stock=6, add_sw and disp_req rise in the same IDLE cycle → ADD taken first. Then add_sw asserted during a DISP → dispense completes (stock 7→6), then ADD follows.
6. Assert reset asynchronously during the 2nd DISP cycle with stock=8 → disp=0 immediately, no disp_done, stock=INIT_STOCK, state IDLE after release.

Source files
------------

// File: rtl/cork_dispenser_ctrl.sv
// Cork depot controller: stock counter, timed dispense and paced refill.
// Optional starve_alarm output enabled by CORK_STARVE_ALARM_EN.
module cork_dispenser_ctrl #(
    parameter int STOCK_W     = 6,
    parameter int MAX_STOCK   = 20,
    parameter int LOW_LEVEL   = 5,
    parameter int INIT_STOCK  = 0,
    parameter int DISP_CYCLES = 3,
    parameter int GAP_CYCLES  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               add_sw,
    input  logic               disp_req,
    output logic               disp,
    output logic               disp_done,
    output logic               add_rolha,
    output logic [STOCK_W-1:0] stock,
    output logic               stock_low,
    output logic               stock_full,
    output logic               busy
`ifdef CORK_STARVE_ALARM_EN
    ,
    output logic               starve_alarm
`endif
);

    localparam int CNT_MAX = (DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [STOCK_W-1:0] MAX_S  = STOCK_W'(MAX_STOCK);
    localparam logic [STOCK_W-1:0] LOW_S  = STOCK_W'(LOW_LEVEL);
    localparam logic [STOCK_W-1:0] INIT_S = STOCK_W'(INIT_STOCK);

    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    generate
        if (MAX_STOCK >= (1 << STOCK_W)) begin : g_chk_w
            $error("MAX_STOCK does not fit in STOCK_W bits");
        end
        if (INIT_STOCK > MAX_STOCK) begin : g_chk_init
            $error("INIT_STOCK exceeds MAX_STOCK");
        end
        if (DISP_CYCLES < 1 || GAP_CYCLES < 1) begin : g_chk_cyc
            $error("DISP_CYCLES and GAP_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        ADD,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic full;
    logic empty;
    logic refill_go;
    logic disp_go;

    assign full  = (stock == MAX_S);
    assign empty = (stock == '0);

    // Refill wins over dispense; the two go-terms are kept exclusive
    assign refill_go = add_sw && !full;
    assign disp_go   = !refill_go && disp_req && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            stock <= INIT_S;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        refill_go: state <= ADD;
                        disp_go: begin
                            state <= DISP;
                            cnt   <= '0;
                        end
                        default: state <= IDLE;
                    endcase
                end
                DISP: begin
                    if (cnt == DISP_LAST) begin
                        state <= IDLE;
                        stock <= stock - 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ADD: begin
                    if (!full) begin
                        stock <= stock + 1'b1;
                    end
                    state <= GAP;
                    cnt   <= '0;
                end
                GAP: begin
                    if (!add_sw || full) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == GAP_LAST) begin
                        state <= ADD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign disp       = (state == DISP);
    assign disp_done  = (state == DISP) && (cnt == DISP_LAST);
    assign add_rolha  = (state == ADD);
    assign busy       = (state != IDLE);
    assign stock_low  = (stock < LOW_S);
    assign stock_full = full;

`ifdef CORK_STARVE_ALARM_EN
    // Sticky until the depot actually receives a cork
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_alarm <= 1'b0;
        end else if (state == ADD) begin
            starve_alarm <= 1'b0;
        end else if (state == IDLE && disp_req && empty && !add_sw) begin
            starve_alarm <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cork_dispenser_ctrl.sv
// Self-checking bench for cork_dispenser_ctrl: vector table, corner
// sequences and a randomized run against a countdown reference model.
module tb_cork_dispenser_ctrl;

    localparam int STOCK_W     = 6;
    localparam int MAX_STOCK   = 20;
    localparam int LOW_LEVEL   = 5;
    localparam int INIT_STOCK  = 0;
    localparam int DISP_CYCLES = 3;
    localparam int GAP_CYCLES  = 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               add_sw = 1'b0;
    logic               disp_req = 1'b0;
    logic               disp;
    logic               disp_done;
    logic               add_rolha;
    logic [STOCK_W-1:0] stock;
    logic               stock_low;
    logic               stock_full;
    logic               busy;
`ifdef CORK_STARVE_ALARM_EN
    logic               starve_alarm;
`endif

    cork_dispenser_ctrl #(
        .STOCK_W    (STOCK_W),
        .MAX_STOCK  (MAX_STOCK),
        .LOW_LEVEL  (LOW_LEVEL),
        .INIT_STOCK (INIT_STOCK),
        .DISP_CYCLES(DISP_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .add_sw    (add_sw),
        .disp_req  (disp_req),
        .disp      (disp),
        .disp_done (disp_done),
        .add_rolha (add_rolha),
        .stock     (stock),
        .stock_low (stock_low),
        .stock_full(stock_full),
        .busy      (busy)
`ifdef CORK_STARVE_ALARM_EN
        ,
        .starve_alarm(starve_alarm)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        add_sw   = 1'b0;
        disp_req = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    // Reference model: activities as countdowns, not FSM states
    int m_stock;
    int m_disp_left;
    int m_gap_left;
    bit m_pulse;
    bit m_alarm;

    task automatic m_reset();
        m_stock     = INIT_STOCK;
        m_disp_left = 0;
        m_gap_left  = 0;
        m_pulse     = 1'b0;
        m_alarm     = 1'b0;
    endtask

    task automatic m_edge(input bit a, input bit r);
        if (m_disp_left > 0) begin
            if (m_disp_left == 1) m_stock = m_stock - 1;
            m_disp_left = m_disp_left - 1;
        end else if (m_pulse) begin
            m_pulse    = 1'b0;
            m_alarm    = 1'b0;
            m_stock    = (m_stock < MAX_STOCK) ? m_stock + 1 : MAX_STOCK;
            m_gap_left = GAP_CYCLES;
        end else if (m_gap_left > 0) begin
            if (!a || m_stock == MAX_STOCK) begin
                m_gap_left = 0;
            end else if (m_gap_left == 1) begin
                m_gap_left = 0;
                m_pulse    = 1'b1;
            end else begin
                m_gap_left = m_gap_left - 1;
            end
        end else begin
            if (a && m_stock < MAX_STOCK) m_pulse = 1'b1;
            else if (r && m_stock != 0) m_disp_left = DISP_CYCLES;
            else if (r && !a) m_alarm = 1'b1;
        end
    endtask

    function automatic int m_flags();
        bit d, dn, ad, bs, lo, fu;
        d  = (m_disp_left > 0);
        dn = (m_disp_left == 1);
        ad = m_pulse;
        bs = (m_disp_left > 0) || m_pulse || (m_gap_left > 0);
        lo = (m_stock < LOW_LEVEL);
        fu = (m_stock == MAX_STOCK);
        return int'({d, dn, ad, bs, lo, fu});
    endfunction

    function automatic int dut_flags();
        return int'({disp, disp_done, add_rolha, busy, stock_low, stock_full});
    endfunction

    typedef struct {
        bit a;
        bit r;
        bit e_disp;
        bit e_done;
        bit e_add;
        bit e_busy;
        int e_stock;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int pulses;
        int last_pulse;
        bit spacing_ok;
        bit saw_disp;
        int guard;

        // a r  disp done add busy stock
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 1, 1, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 1, 1};
        tbl[3]  = '{1, 0, 0, 0, 1, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 2};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 2};
        tbl[6]  = '{0, 1, 1, 0, 0, 1, 2};
        tbl[7]  = '{0, 0, 1, 0, 0, 1, 2};
        tbl[8]  = '{0, 0, 1, 1, 0, 1, 2};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 1, 0, 0, 1, 1, 1};
        tbl[11] = '{1, 1, 0, 0, 0, 1, 2};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 2};
        tbl[13] = '{0, 1, 1, 0, 0, 1, 2};
        tbl[14] = '{1, 0, 1, 0, 0, 1, 2};
        tbl[15] = '{1, 0, 1, 1, 0, 1, 2};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 1};
        tbl[17] = '{1, 0, 0, 0, 1, 1, 1};
        tbl[18] = '{0, 0, 0, 0, 0, 1, 2};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 2};

        // Reset state while reset is held
        add_sw   = 1'b0;
        disp_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", dut_flags(), int'(6'b000010));
        chk("reset_stock", int'(stock), INIT_STOCK);
        reset = 1'b0;
        #1;

        // Vector table
        for (int i = 0; i < 20; i++) begin
            add_sw   = tbl[i].a;
            disp_req = tbl[i].r;
            step();
            chk($sformatf("vec%0d_flags", i),
                int'({disp, disp_done, add_rolha, busy}),
                int'({tbl[i].e_disp, tbl[i].e_done, tbl[i].e_add, tbl[i].e_busy}));
            chk($sformatf("vec%0d_stock", i), int'(stock), tbl[i].e_stock);
            chk($sformatf("vec%0d_low", i), int'(stock_low),
                int'(tbl[i].e_stock < LOW_LEVEL));
        end

        // Refill held 10 cycles from empty
        do_reset();
        pulses     = 0;
        last_pulse = -10;
        spacing_ok = 1'b1;
        add_sw     = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (add_rolha) begin
                if (pulses > 0 && c - last_pulse != GAP_CYCLES + 1) spacing_ok = 1'b0;
                pulses++;
                last_pulse = c;
            end
        end
        add_sw = 1'b0;
        guard  = 0;
        while (busy && guard < 10) begin
            step();
            if (add_rolha) pulses++;
            guard++;
        end
        chk("refill10_pulses", pulses, 5);
        chk("refill10_spacing", int'(spacing_ok), 1);
        chk("refill10_stock", int'(stock), 5);
        chk("refill10_low", int'(stock_low), 0);
        chk("refill10_busy", int'(busy), 0);

        // Continuous refill saturates at capacity
        do_reset();
        add_sw = 1'b1;
        guard  = 0;
        while (!stock_full && guard < 200) begin
            step();
            guard++;
        end
        chk("fill_reached", int'(stock_full), 1);
        pulses = 0;
        repeat (6) begin
            step();
            if (add_rolha) pulses++;
        end
        chk("fill_stock", int'(stock), MAX_STOCK);
        chk("fill_no_more_pulses", pulses, 0);
        chk("fill_idle", int'(busy), 0);
        add_sw = 1'b0;

        // Starved request dropped
        do_reset();
        saw_disp = 1'b0;
        disp_req = 1'b1;
        repeat (4) begin
            step();
            if (disp) saw_disp = 1'b1;
        end
        disp_req = 1'b0;
        step();
        chk("starve_no_disp", int'(saw_disp), 0);
        chk("starve_stock", int'(stock), 0);
`ifdef CORK_STARVE_ALARM_EN
        chk("starve_alarm_set", int'(starve_alarm), 1);
`endif
        add_sw = 1'b1;
        step();
        chk("starve_refill_pulse", int'(add_rolha), 1);
`ifdef CORK_STARVE_ALARM_EN
        chk("starve_alarm_held", int'(starve_alarm), 1);
`endif
        add_sw = 1'b0;
        step();
        chk("starve_refill_stock", int'(stock), 1);
`ifdef CORK_STARVE_ALARM_EN
        chk("starve_alarm_clr", int'(starve_alarm), 0);
`endif

        // Asynchronous reset during the second dispense cycle
        do_reset();
        add_sw = 1'b1;
        guard  = 0;
        while (int'(stock) != 8 && guard < 100) begin
            step();
            guard++;
        end
        add_sw = 1'b0;
        step();
        step();
        chk("arst_stock8", int'(stock), 8);
        disp_req = 1'b1;
        step();
        disp_req = 1'b0;
        step();
        chk("arst_disp2", int'({disp, disp_done}), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_flags", int'({disp, disp_done, busy}), 0);
        chk("arst_stock", int'(stock), INIT_STOCK);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("arst_after", int'({disp, disp_done, busy}), 0);

        // Randomized run against the model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) add_sw = ~add_sw;
            disp_req = ($urandom_range(0, 2) == 0);
            m_edge(add_sw, disp_req);
            step();
            chk("rand_flags", dut_flags(), m_flags());
            chk("rand_stock", int'(stock), m_stock);
`ifdef CORK_STARVE_ALARM_EN
            chk("rand_alarm", int'(starve_alarm), int'(m_alarm));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
